pipeline_ctrl: RTL

Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EXE, MEM, WB). It merges four hazard sources into per-stage register enables, flushes and a PC redirect select:
- load-use from the ID-stage detector
- branch/jump mispredict resolved in EXE
- multi-cycle data-memory waits
- halt (ecall) retirement

It also owns a memory-wait timeout and saturating hazard performance counters.

---
 rtl/pipeline_ctrl_if.sv | 31 +++
 rtl/pipeline_ctrl.sv | 84 ++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs, stage control outputs and hazard counters of the pipeline sequencer
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
   logic load_use;
   logic mispredict_exe;
   logic mem_req;
   logic mem_ready;
   logic halt_wb;
   logic pc_en;
   logic pc_redirect;
   logic if_id_en;
   logic if_id_flush;
   logic id_exe_en;
   logic id_exe_flush;
   logic exe_mem_en;
   logic mem_wb_en;
   logic halted;
   logic err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] memwait_cnt;
   modport master (
      output load_use, mispredict_exe, mem_req, mem_ready, halt_wb,
      input  pc_en, pc_redirect, if_id_en, if_id_flush, id_exe_en, id_exe_flush,
      input  exe_mem_en, mem_wb_en, halted, err, stall_cnt, flush_cnt, memwait_cnt
   );
   modport slave (
      input  load_use, mispredict_exe, mem_req, mem_ready, halt_wb,
      output pc_en, pc_redirect, if_id_en, if_id_flush, id_exe_en, id_exe_flush,
      output exe_mem_en, mem_wb_en, halted, err, stall_cnt, flush_cnt, memwait_cnt
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: merges load-use, mispredict, memory-wait and halt hazards into stage enables/flushes
module pipeline_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input logic clk,
   input logic rst,
   pipeline_ctrl_if.slave bus
);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] TO  = WW'(TIMEOUT);
   localparam logic [WW-1:0] ONE = WW'(1);
   typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;
   state_t state;
   logic [WW-1:0] wait_cnt;
   logic [WW-1:0] next_wait;
   logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;
   logic halted, err;
   logic freeze, hold, active, mp, lu;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return &c ? c : c + CNT_W'(1);
   endfunction

   // Decide whether the pipeline advances this cycle and which hazard wins when it does
   always_comb begin
      freeze    = state == RUN && bus.mem_req && !bus.mem_ready;
      hold      = freeze || (state == MEM_WAIT && !bus.mem_ready);
      next_wait = freeze ? ONE : wait_cnt + ONE;
      active    = !rst && ((state == RUN && !freeze) || (state == MEM_WAIT && bus.mem_ready));
      mp        = active && bus.mispredict_exe;
      lu        = active && !bus.mispredict_exe && bus.load_use;
   end

   assign bus.pc_en        = active && !lu;
   assign bus.pc_redirect  = mp;
   assign bus.if_id_en     = active && !lu;
   assign bus.if_id_flush  = mp;
   assign bus.id_exe_en    = active;
   assign bus.id_exe_flush = mp || lu;
   assign bus.exe_mem_en   = active;
   assign bus.mem_wb_en    = active;
   assign bus.halted       = halted;
   assign bus.err          = err;
   assign bus.stall_cnt    = stall_cnt;
   assign bus.flush_cnt    = flush_cnt;
   assign bus.memwait_cnt  = memwait_cnt;

   // Sequencer state, wait timer, sticky halt/error flags and saturating hazard counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         halted      <= 1'b0;
         err         <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         memwait_cnt <= '0;
      end else if (state != HALTED) begin
         if (hold) begin
            memwait_cnt <= sat_inc(memwait_cnt);
            if (next_wait == TO) begin
               state    <= HALTED;
               halted   <= 1'b1;
               err      <= 1'b1;
               wait_cnt <= '0;
            end else begin
               state    <= MEM_WAIT;
               wait_cnt <= next_wait;
            end
         end else begin
            wait_cnt <= '0;
            if (mp) flush_cnt <= sat_inc(flush_cnt);
            if (lu) stall_cnt <= sat_inc(stall_cnt);
            if (bus.halt_wb) begin
               state  <= HALTED;
               halted <= 1'b1;
            end else begin
               state <= RUN;
            end
         end
      end
   end
endmodule
